ts_packet_capture: RTL and testbench
====================================

// Module: ts_packet_capture
// PURPOSE
//  Receive end of the TS byte stream produced by tsp_ram (ts_out/ts_out_valid/ts_out_sync).
//  Aligns on packet sync, optionally filters on one PID, and packs one 188-byte packet into a word buffer.
//  The host reads the buffer through the same wen/waddr/ren/raddr register port style used on tsp_ram,
//  then releases the buffer for the next capture.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32    register data width; byte packing assumes 32
//  OPT_MEM_ADDR_BITS   10    register address is OPT_MEM_ADDR_BITS+1 bits
//  PACK_BYTE_SIZE      188   TS packet length in bytes; PACK_WORD_SIZE = 47
//  ADDR_TS_DATA_BASE   128   word address of packet word 0
// PORTS
//  clk        in   1     single clock for stream and register port
//  rst_n      in   1     asynchronous active-low reset
//  ts_valid   in   1     ts_data is valid this cycle
//  ts_sync    in   1     qualifies the first byte of a packet; valid only with ts_valid
//  ts_data    in   8     stream byte
//  wen        in   1     register write strobe
//  waddr      in   OPT_MEM_ADDR_BITS+1   write word address
//  wdata      in   C_S_AXI_DATA_WIDTH    write data
//  ren        in   1     register read enable
//  raddr      in   OPT_MEM_ADDR_BITS+1   read word address
//  rdata      out  C_S_AXI_DATA_WIDTH    read data, registered
//  pkt_ready  out  1     complete packet held in buffer
// BEHAVIOUR
//  Registers:
//   0 CTRL    RW  bit0 = capture enable; bit1 = PID filter enable
//   1 PID     RW  [12:0] match PID
//   2 STATUS  RO  bit0 = pkt_ready; bit1 = capture in progress
//   3 ACK     WO  any write releases the buffer
//   4 DROPS   RO  packets lost while the buffer was full; 32-bit, saturates at 0xFFFFFFFF
//   128..174  RO  packet words
//  Undefined addresses read as 0. Writes to RO addresses are ignored.
//  Reset: all outputs, registers, counters and the FSM are 0 / IDLE. Buffer contents are don't-care.
//  rdata: when ren=1, rdata = mem[raddr] on the next clk edge; otherwise it holds its last value. Latency is 1 cycle.
//  Packing: byte k lands in word k/4, bits [8*(k%4)+7 : 8*(k%4)]. Byte 0 (0x47) is the LSB of word 0.
//  FSM:
//   IDLE
//    - Waits for ts_valid & ts_sync & ts_data==8'h47 & enable.
//    - On that cycle stores byte 0, sets byte counter to 1, goes to CAPT.
//    - A sync byte other than 0x47 is ignored.
//   CAPT
//    - Each ts_valid stores a byte and increments the counter. Gaps in ts_valid are allowed.
//    - After byte 2 is stored: if the filter is enabled and {byte1[4:0], byte2} != PID, go to IDLE. No drop is counted.
//    - Sync with valid mid-packet (counter != 0) aborts the current packet and restarts it at byte 0 on the same cycle,
//      provided the byte is 0x47; otherwise go to IDLE.
//    - Storing byte 187 goes to FULL. pkt_ready=1 from the next cycle.
//    - Clearing enable goes to IDLE at once; the partial packet is discarded.
//   FULL
//    - The buffer is frozen. Each ts_valid & ts_sync increments DROPS (saturating).
//    - ACK write -> pkt_ready=0 next cycle, FSM goes to IDLE.
//    - ACK together with a valid 0x47 sync in the same cycle: ACK wins, that byte is captured as byte 0, FSM goes to CAPT, no drop.
//    - ACK outside FULL has no effect.
//  Register write and capture in the same cycle are independent; a CTRL write takes effect on the next cycle.
//  A read of a packet word while FULL always returns the frozen data.
//  Async reset mid-capture returns to IDLE at once.
// TESTING
//  1. PID 0x157F, filter on, one packet 47 15 7F 10 ..
//     -> pkt_ready=1; word128=0x107F1547; word174 = bytes 184..187.
//  2. Filter on, PID 0x0191, stream of PID 0x157F packets
//     -> pkt_ready stays 0; STATUS bit1 pulses and clears after byte 2.
//  3. Buffer FULL, 3 more syncs arrive, then ACK
//     -> DROPS=3, pkt_ready=0, the next packet is captured intact.
//  4. Sync at byte 100 of a packet
//     -> restart; the captured packet equals the second packet, byte-exact.
//  5. ts_valid on 1 cycle in 4 (as in the tsp_ram bench)
//     -> same captured words as a continuous stream.
//  6. rst_n low for 1 cycle mid-capture
//     -> rdata=0, pkt_ready=0, DROPS=0, FSM in IDLE, the next sync starts a clean capture.

Source files
------------

// File: rtl/ts_packet_capture_if.sv
// Bundles the TS byte stream and the host register port of ts_packet_capture.
// master drives the stream and register requests; slave is the capture block.
// Read data and pkt_ready flow back from the slave.
interface ts_packet_capture_if #(
    parameter int DW = 32,
    parameter int AW = 11
);
    logic          ts_valid;
    logic          ts_sync;
    logic [7:0]    ts_data;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          pkt_ready;

    modport master (
        output ts_valid, ts_sync, ts_data, wen, waddr, wdata, ren, raddr,
        input  rdata, pkt_ready
    );

    modport slave (
        input  ts_valid, ts_sync, ts_data, wen, waddr, wdata, ren, raddr,
        output rdata, pkt_ready
    );
endinterface

// File: rtl/ts_packet_capture.sv
// Captures one sync-aligned 188-byte TS packet (optional PID filter) into a word buffer read by the host.
// Latency: a byte is stored on the edge it is valid; pkt_ready rises the cycle after byte 187; rdata 1 cycle after ren.
// Backpressure: none on the stream; while the buffer is full, packets are dropped and counted until ACK.
module ts_packet_capture #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 10,
    parameter int PACK_BYTE_SIZE     = 188,
    parameter int ADDR_TS_DATA_BASE  = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    ts_packet_capture_if.slave bus
);
    localparam int DW             = C_S_AXI_DATA_WIDTH;
    localparam int AW             = OPT_MEM_ADDR_BITS + 1;
    localparam int PACK_WORD_SIZE = PACK_BYTE_SIZE / 4;

    localparam logic [AW-1:0] A_CTRL   = AW'(0);
    localparam logic [AW-1:0] A_PID    = AW'(1);
    localparam logic [AW-1:0] A_STATUS = AW'(2);
    localparam logic [AW-1:0] A_ACK    = AW'(3);
    localparam logic [AW-1:0] A_DROPS  = AW'(4);
    localparam logic [AW-1:0] A_BASE   = AW'(ADDR_TS_DATA_BASE);
    localparam logic [7:0]    LAST_IDX = 8'(PACK_BYTE_SIZE - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {S_IDLE, S_CAPT, S_FULL} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [4:0]    pid_hi_q, pid_hi_d;
    logic [31:0]   drops_q, drops_d;
    logic [1:0]    ctrl_q;
    logic [12:0]   pid_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rd_val;

    // Packet buffer: no reset, contents are only meaningful once FULL.
    logic [DW-1:0] mem [0:PACK_WORD_SIZE-1];

    logic          st_en;
    logic [7:0]    st_idx;
    logic          is_sof;
    logic          ack;
    logic [AW-1:0] roff;
    logic          rd_in_buf;

    assign is_sof    = bus.ts_valid && bus.ts_sync && (bus.ts_data == SYNC_BYTE);
    assign ack       = bus.wen && (bus.waddr == A_ACK) && (state_q == S_FULL);
    assign roff      = bus.raddr - A_BASE;
    assign rd_in_buf = (bus.raddr >= A_BASE) && (roff < AW'(PACK_WORD_SIZE));

    assign bus.rdata     = rdata_q;
    assign bus.pkt_ready = (state_q == S_FULL);

    // Capture FSM: packet alignment, PID filter, drop counting and buffer release.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pid_hi_d = pid_hi_q;
        drops_d  = drops_q;
        st_en    = 1'b0;
        st_idx   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0] && is_sof) begin
                    st_en   = 1'b1;
                    st_idx  = 8'd0;
                    cnt_d   = 8'd1;
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                if (!ctrl_q[0]) begin
                    // Enable cleared: the partial packet is simply abandoned.
                    state_d = S_IDLE;
                end else if (bus.ts_valid && bus.ts_sync) begin
                    // Early sync: restart on a good sync byte, otherwise resynchronise from IDLE.
                    if (bus.ts_data == SYNC_BYTE) begin
                        st_en  = 1'b1;
                        st_idx = 8'd0;
                        cnt_d  = 8'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.ts_valid) begin
                    st_en = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        pid_hi_d = bus.ts_data[4:0];
                    end
                    if ((cnt_q == 8'd2) && ctrl_q[1] && ({pid_hi_q, bus.ts_data} != pid_q)) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == LAST_IDX) begin
                        state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (ack) begin
                    // Release wins over a same-cycle sync; that sync byte starts the next packet.
                    if (ctrl_q[0] && is_sof) begin
                        st_en   = 1'b1;
                        st_idx  = 8'd0;
                        cnt_d   = 8'd1;
                        state_d = S_CAPT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.ts_valid && bus.ts_sync && (drops_q != 32'hFFFF_FFFF)) begin
                    drops_d = drops_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register read mux; unmapped addresses return zero.
    always_comb begin
        rd_val = '0;
        case (bus.raddr)
            A_CTRL:   rd_val = DW'(ctrl_q);
            A_PID:    rd_val = DW'(pid_q);
            A_STATUS: rd_val = DW'({state_q == S_CAPT, state_q == S_FULL});
            A_DROPS:  rd_val = DW'(drops_q);
            default: begin
                if (rd_in_buf) begin
                    rd_val = mem[roff[5:0]];
                end
            end
        endcase
    end

    // Byte-lane write into the packet buffer: byte k goes to word k/4, lane k%4.
    always_ff @(posedge clk) begin
        if (st_en) begin
            mem[st_idx[7:2]][8*st_idx[1:0] +: 8] <= bus.ts_data;
        end
    end

    // FSM, counters and host-visible registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pid_hi_q <= '0;
            drops_q  <= '0;
            ctrl_q   <= '0;
            pid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pid_hi_q <= pid_hi_d;
            drops_q  <= drops_d;
            if (bus.wen && (bus.waddr == A_CTRL)) begin
                ctrl_q <= bus.wdata[1:0];
            end
            if (bus.wen && (bus.waddr == A_PID)) begin
                pid_q <= bus.wdata[12:0];
            end
            if (bus.ren) begin
                rdata_q <= rd_val;
            end
        end
    end
endmodule

// File: tb/tb_ts_packet_capture.sv
module tb_ts_packet_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ts_packet_capture_if #(.DW(32), .AW(11)) bus ();

    ts_packet_capture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_vld = 1'b0;

    logic [7:0] pkt [0:187];

    // Read-response monitor: rdata is valid the cycle after ren.
    always @(posedge clk) rd_vld <= bus.ren;

    always @(negedge clk) begin
        if (rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got=%h required=none", bus.rdata);
            end else begin
                logic [31:0] e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (bus.rdata !== e) begin
                    errors++;
                    $display("FAIL %s got=%h required=%h", n, bus.rdata, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", n, got, req);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.wen = 1'b1; bus.waddr = 11'(a); bus.wdata = d;
        tick();
        bus.wen = 1'b0;
    endtask

    task automatic rd(input int a, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        bus.ren = 1'b1; bus.raddr = 11'(a);
        tick();
        bus.ren = 1'b0;
    endtask

    task automatic send_byte(input logic s, input logic [7:0] d, input int gap);
        bus.ts_valid = 1'b1; bus.ts_sync = s; bus.ts_data = d;
        tick();
        bus.ts_valid = 1'b0; bus.ts_sync = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    // Reference packet: 47, PID hi, PID lo, 0x10, then (seed + k) for k >= 4.
    task automatic build_pkt(input logic [12:0] pid, input logic [7:0] seed);
        pkt[0] = 8'h47;
        pkt[1] = {3'b000, pid[12:8]};
        pkt[2] = pid[7:0];
        pkt[3] = 8'h10;
        for (int k = 4; k < 188; k++) pkt[k] = 8'(seed + 8'(k));
    endtask

    task automatic send_pkt(input int nbytes, input int gap);
        for (int k = 0; k < nbytes; k++) send_byte(k == 0, pkt[k], gap);
    endtask

    function automatic logic [31:0] model_word(input int w);
        return {pkt[4*w+3], pkt[4*w+2], pkt[4*w+1], pkt[4*w]};
    endfunction

    task automatic check_words(input string tag);
        int ws [4] = '{0, 1, 23, 46};
        for (int i = 0; i < 4; i++) rd(128 + ws[i], model_word(ws[i]), $sformatf("%s_w%0d", tag, ws[i]));
    endtask

    initial begin
        bus.ts_valid = 0; bus.ts_sync = 0; bus.ts_data = 0;
        bus.wen = 0; bus.waddr = 0; bus.wdata = 0;
        bus.ren = 0; bus.raddr = 0;
        repeat (3) tick();
        chk("reset_rdata", bus.rdata, 32'h0);
        chk("reset_pkt_ready", 32'(bus.pkt_ready), 32'h0);
        rst_n = 1'b1;
        tick();
        rd(0, 32'h0, "reset_ctrl");
        rd(2, 32'h0, "reset_status");
        rd(4, 32'h0, "reset_drops");

        // 1: filter on, matching PID 0x157F, byte k = k for k >= 4.
        wr(1, 32'h0000_157F);
        wr(0, 32'h3);
        rd(1, 32'h0000_157F, "pid_readback");
        build_pkt(13'h157F, 8'h00);
        send_pkt(188, 0);
        chk("t1_pkt_ready", 32'(bus.pkt_ready), 32'h1);
        rd(128, 32'h107F_1547, "t1_word128");
        rd(129, 32'h0706_0504, "t1_word129");
        rd(174, 32'hBBBA_B9B8, "t1_word174");
        rd(2, 32'h1, "t1_status_full");
        rd(5, 32'h0, "undef_addr");
        rd(175, 32'h0, "past_buffer");
        wr(2, 32'hFFFF_FFFF);
        rd(2, 32'h1, "status_ro");

        // 3: buffer full, three syncs dropped, buffer frozen, then ACK.
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b1, 8'h47, 0);
            send_byte(1'b0, 8'hAA, 1);
        end
        rd(4, 32'h3, "t3_drops");
        rd(128, 32'h107F_1547, "t3_frozen128");
        wr(3, 32'h1);
        chk("t3_ack_pkt_ready", 32'(bus.pkt_ready), 32'h0);
        rd(2, 32'h0, "t3_status_idle");
        build_pkt(13'h157F, 8'h20);
        send_pkt(188, 0);
        chk("t3_next_pkt_ready", 32'(bus.pkt_ready), 32'h1);
        check_words("t3");
        rd(4, 32'h3, "t3_drops_kept");
        wr(3, 32'h1);

        // 2: filter on with PID 0x0191; 0x157F packets are rejected after byte 2.
        wr(1, 32'h0000_0191);
        build_pkt(13'h157F, 8'h40);
        send_byte(1'b1, pkt[0], 0);
        rd(2, 32'h2, "t2_status_capt");
        send_byte(1'b0, pkt[1], 0);
        send_byte(1'b0, pkt[2], 0);
        rd(2, 32'h0, "t2_status_dropped");
        for (int k = 3; k < 188; k++) send_byte(1'b0, pkt[k], 0);
        send_pkt(188, 0);
        chk("t2_pkt_ready", 32'(bus.pkt_ready), 32'h0);
        rd(4, 32'h3, "t2_no_drop");

        // 4: filter off; sync at byte 100 restarts, second packet wins.
        wr(0, 32'h1);
        build_pkt(13'h0AAA, 8'h33);
        send_pkt(100, 0);
        build_pkt(13'h0BBB, 8'h55);
        send_pkt(188, 0);
        chk("t4_pkt_ready", 32'(bus.pkt_ready), 32'h1);
        rd(128, 32'h10BB_0B47, "t4_word128");
        check_words("t4");
        wr(3, 32'h1);

        // 5: ts_valid one cycle in four.
        build_pkt(13'h0CCC, 8'h77);
        send_pkt(188, 3);
        chk("t5_pkt_ready", 32'(bus.pkt_ready), 32'h1);
        check_words("t5");
        wr(3, 32'h1);

        // 6: reset pulse mid-capture.
        build_pkt(13'h0DDD, 8'h11);
        send_pkt(50, 0);
        rst_n = 1'b0;
        tick();
        chk("t6_rdata", bus.rdata, 32'h0);
        chk("t6_pkt_ready", 32'(bus.pkt_ready), 32'h0);
        rst_n = 1'b1;
        tick();
        rd(4, 32'h0, "t6_drops");
        rd(2, 32'h0, "t6_status");
        rd(0, 32'h0, "t6_ctrl");
        wr(0, 32'h1);
        build_pkt(13'h0EEE, 8'h99);
        send_pkt(188, 0);
        chk("t6_pkt_ready_after", 32'(bus.pkt_ready), 32'h1);
        check_words("t6");

        repeat (4) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
